// File: rtl/sriov_ext_cap_regs.sv
// SR-IOV Extended Capability register block with byte-enabled writes, registered
// reads and a VF Enable sequencer that gates the VF population seen by the function.
module sriov_ext_cap_regs #(
    parameter logic [11:0] CAP_OFFSET      = 12'h160,
    parameter logic [11:0] NEXT_PTR        = 12'h000,
    parameter logic [3:0]  CAP_VER         = 4'h1,
    parameter logic [31:0] SRIOV_CAPS      = 32'h0,
    parameter int          TOTAL_VFS       = 16,
    parameter logic [15:0] FIRST_VF_OFFSET = 16'h0001,
    parameter logic [15:0] VF_STRIDE       = 16'h0001,
    parameter logic [15:0] VF_DEVICE_ID    = 16'h0000,
    parameter int          ENABLE_WAIT     = 1000,
    parameter int          DISABLE_WAIT    = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] addr,
    input  logic        wr_en,
    input  logic [3:0]  wr_be,
    input  logic [31:0] wr_data,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        rd_hit,
    output logic        is_last_cap,
    output logic        vf_active,
    output logic        vf_busy,
    output logic        vf_reset,
    output logic [15:0] num_vfs_active,
    output logic        vf_mse
);

    localparam int MAX_WAIT = (ENABLE_WAIT > DISABLE_WAIT) ? ENABLE_WAIT : DISABLE_WAIT;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] EN_LOAD  = CNT_W'(ENABLE_WAIT - 1);
    localparam logic [CNT_W-1:0] DIS_LOAD = CNT_W'(DISABLE_WAIT - 1);
    localparam logic [15:0]      TVFS     = 16'(TOTAL_VFS);
    localparam logic [9:0]       BASE_DW  = CAP_OFFSET[11:2];

    typedef enum logic [1:0] {S_OFF, S_ENABLING, S_ON, S_DISABLING} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      nva_q, nva_d;
    logic             vf_reset_q, vf_reset_d;

    logic        ctrl_vfe, ctrl_mse, ctrl_ari;
    logic [15:0] num_vfs;

    logic [9:0]  dw_off;
    logic        in_win;
    logic [2:0]  reg_sel;
    logic [31:0] rd_mux;
    logic [15:0] num_merged;
    logic        cfg_locked;
    logic        unused_ok;

    assign dw_off    = addr[11:2] - BASE_DW;
    assign in_win    = (addr[11:2] >= BASE_DW) && (dw_off < 10'd8);
    assign reg_sel   = dw_off[2:0];
    assign unused_ok = ^{1'b0, addr[1:0], wr_data[31:16], wr_be[3:2]};

    // Read view always reflects the pre-write register state of this cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        rd_mux = 32'h0;
        case (reg_sel)
            3'd0: rd_mux = {NEXT_PTR, CAP_VER, 16'h0010};
            3'd1: rd_mux = SRIOV_CAPS;
            3'd2: rd_mux = {16'h0, 11'h0, ctrl_ari, ctrl_mse, 2'b00, ctrl_vfe};
            3'd3: rd_mux = {TVFS, TVFS};
            3'd4: rd_mux = {16'h0, num_vfs};
            3'd5: rd_mux = {VF_STRIDE, FIRST_VF_OFFSET};
            3'd6: rd_mux = {VF_DEVICE_ID, 16'h0};
            default: rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= 32'h0;
            rd_valid <= 1'b0;
            rd_hit   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            rd_valid <= rd_en;
            rd_hit   <= rd_en && in_win;
            rd_data  <= (rd_en && in_win) ? rd_mux : 32'h0;
        end
    end

    // NumVFs and ARI are frozen while VFs are enabled or a sequence is running.
    assign cfg_locked = ctrl_vfe || (state_q != S_OFF);
    assign num_merged = {wr_be[1] ? wr_data[15:8] : num_vfs[15:8],
                         wr_be[0] ? wr_data[7:0]  : num_vfs[7:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_vfe <= 1'b0;
            ctrl_mse <= 1'b0;
            ctrl_ari <= 1'b0;
            num_vfs  <= 16'h0;
        end else if (wr_en && in_win) begin
            case (reg_sel)
                3'd2: if (wr_be[0]) begin
                    ctrl_vfe <= wr_data[0];
                    ctrl_mse <= wr_data[3];
                    if (!cfg_locked) ctrl_ari <= wr_data[4];
                end
                3'd4: if ((|wr_be[1:0]) && !cfg_locked && (num_merged <= TVFS))
                    num_vfs <= num_merged;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_OFF;
            cnt_q      <= '0;
            nva_q      <= 16'h0;
            vf_reset_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            nva_q      <= nva_d;
            vf_reset_q <= vf_reset_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        nva_d      = nva_q;
        vf_reset_d = 1'b0;
        case (state_q)
            S_OFF: if (ctrl_vfe && (num_vfs != 16'h0)) begin
                state_d = S_ENABLING;
                cnt_d   = EN_LOAD;
                nva_d   = num_vfs;
            end
            S_ENABLING, S_ON: begin
                if (!ctrl_vfe) begin
                    state_d    = S_DISABLING;
                    cnt_d      = DIS_LOAD;
                    vf_reset_d = 1'b1;
                end else if (state_q == S_ENABLING) begin
                    if (cnt_q == '0) state_d = S_ON;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            S_DISABLING: begin
                if (cnt_q == '0) begin
                    state_d = S_OFF;
                    nva_d   = 16'h0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_OFF;
        endcase
    end

    assign is_last_cap    = (NEXT_PTR == 12'h000);
    assign vf_active      = (state_q == S_ON);
    assign vf_busy        = (state_q == S_ENABLING) || (state_q == S_DISABLING);
    assign vf_mse         = ctrl_mse && vf_active;
    assign vf_reset       = vf_reset_q;
    assign num_vfs_active = nva_q;

endmodule

// File: tb/tb_sriov_ext_cap_regs.sv
// Self-checking bench: directed scenarios plus random traffic against a
// timestamp-based behavioural model of the SR-IOV capability.
module tb_sriov_ext_cap_regs;

    localparam logic [11:0] CAP_OFFSET      = 12'h160;
    localparam logic [11:0] NEXT_PTR        = 12'h000;
    localparam logic [3:0]  CAP_VER         = 4'h1;
    localparam logic [31:0] SRIOV_CAPS      = 32'h0;
    localparam int          TOTAL_VFS       = 16;
    localparam logic [15:0] FIRST_VF_OFFSET = 16'h0001;
    localparam logic [15:0] VF_STRIDE       = 16'h0001;
    localparam logic [15:0] VF_DEVICE_ID    = 16'h0000;
    localparam int          ENABLE_WAIT     = 1000;
    localparam int          DISABLE_WAIT    = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] addr = '0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_be = '0;
    logic [31:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid, rd_hit, is_last_cap, vf_active, vf_busy, vf_reset, vf_mse;
    logic [15:0] num_vfs_active;

    sriov_ext_cap_regs #(
        .CAP_OFFSET(CAP_OFFSET), .NEXT_PTR(NEXT_PTR), .CAP_VER(CAP_VER),
        .SRIOV_CAPS(SRIOV_CAPS), .TOTAL_VFS(TOTAL_VFS),
        .FIRST_VF_OFFSET(FIRST_VF_OFFSET), .VF_STRIDE(VF_STRIDE),
        .VF_DEVICE_ID(VF_DEVICE_ID), .ENABLE_WAIT(ENABLE_WAIT),
        .DISABLE_WAIT(DISABLE_WAIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wr_en(wr_en), .wr_be(wr_be),
        .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_hit(rd_hit), .is_last_cap(is_last_cap), .vf_active(vf_active),
        .vf_busy(vf_busy), .vf_reset(vf_reset), .num_vfs_active(num_vfs_active),
        .vf_mse(vf_mse)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural model: register contents plus a phase with an absolute end time.
    bit          m_vfe, m_mse, m_ari;
    int          m_num, m_nva;
    int          m_phase;          // 0 off, 1 enabling, 2 on, 3 disabling
    longint      cyc, t_end;
    bit          m_pulse, m_rv, m_rh;
    logic [31:0] m_rd;
    logic [31:0] last_rd;
    logic        last_hit;

    function automatic int win_off(input logic [11:0] a);
        return int'({a[11:2], 2'b00}) - int'(CAP_OFFSET);
    endfunction

    function automatic bit in_win(input logic [11:0] a);
        int off = win_off(a);
        return (off >= 0) && (off <= 28);
    endfunction

    function automatic logic [31:0] ref_read(input logic [11:0] a);
        if (!in_win(a)) return 32'h0;
        case (win_off(a))
            0:  return {NEXT_PTR, CAP_VER, 16'h0010};
            4:  return SRIOV_CAPS;
            8:  return 32'(m_vfe) | (32'(m_mse) << 3) | (32'(m_ari) << 4);
            12: return (32'(TOTAL_VFS) << 16) | 32'(TOTAL_VFS);
            16: return 32'(m_num);
            20: return {VF_STRIDE, FIRST_VF_OFFSET};
            24: return {VF_DEVICE_ID, 16'h0};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_vfe = 0; m_mse = 0; m_ari = 0; m_num = 0; m_nva = 0;
        m_phase = 0; m_pulse = 0; m_rv = 0; m_rh = 0; m_rd = 0;
    endtask

    task automatic model_edge(input bit r, input bit w, input logic [11:0] a,
                              input logic [3:0] be, input logic [31:0] d);
        bit locked = m_vfe || (m_phase != 0);
        int merged;
        cyc++;
        m_rv = r;
        m_rh = r && in_win(a);
        m_rd = m_rh ? ref_read(a) : 32'h0;
        m_pulse = 0;
        case (m_phase)
            0: if (m_vfe && m_num != 0) begin
                m_phase = 1; t_end = cyc + ENABLE_WAIT; m_nva = m_num;
            end
            1, 2: if (!m_vfe) begin
                m_phase = 3; t_end = cyc + DISABLE_WAIT; m_pulse = 1;
            end else if (m_phase == 1 && cyc == t_end) begin
                m_phase = 2;
            end
            default: if (cyc == t_end) begin
                m_phase = 0; m_nva = 0;
            end
        endcase
        if (w && in_win(a)) begin
            if (win_off(a) == 8 && be[0]) begin
                m_vfe = d[0];
                m_mse = d[3];
                if (!locked) m_ari = d[4];
            end
            if (win_off(a) == 16) begin
                merged = m_num;
                if (be[0]) merged = (merged & 32'hFF00) | int'(d[7:0]);
                if (be[1]) merged = (merged & 32'h00FF) | (int'(d[15:8]) << 8);
                if ((be[1:0] != 0) && !locked && merged <= TOTAL_VFS) m_num = merged;
            end
        end
    endtask

    task automatic cycle(input bit r, input bit w, input logic [11:0] a,
                         input logic [3:0] be, input logic [31:0] d);
        rd_en = r; wr_en = w; addr = a; wr_be = be; wr_data = d;
        @(posedge clk);
        model_edge(r, w, a, be, d);
        #1;
        check("outs", {rd_valid, rd_hit, vf_active, vf_busy, vf_reset, vf_mse, num_vfs_active},
              {m_rv, m_rh, m_phase == 2, m_phase == 1 || m_phase == 3, m_pulse,
               m_mse && m_phase == 2, 16'(m_nva)});
        if (m_rv) check("rd_data", rd_data, m_rd);
        last_rd = rd_data;
        last_hit = rd_hit;
        rd_en = 0; wr_en = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 0, 12'h0, 4'h0, 32'h0);
    endtask

    task automatic wr(input logic [11:0] a, input logic [3:0] be, input logic [31:0] d);
        cycle(0, 1, a, be, d);
    endtask

    task automatic rd(input logic [11:0] a);
        cycle(1, 0, a, 4'h0, 32'h0);
    endtask

    task automatic wait_active(input string tag, input int limit);
        int i = 0;
        while (!vf_active && i < limit) begin idle(1); i++; end
        check(tag, vf_active, 1'b1);
    endtask

    initial begin
        int busy_cnt, pulses, i;
        bit saw_active;
        bit r, w;
        logic [11:0] a;
        logic [31:0] d;

        model_reset();
        cyc = 0; t_end = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {rd_data, rd_valid, rd_hit, vf_active, vf_busy, vf_reset, vf_mse,
                             num_vfs_active}, 0);
        @(negedge clk);
        rst_n = 1;
        check("is_last_cap", is_last_cap, 1'b1);

        rd(12'h160);
        check("hdr", last_rd, 32'h0001_0010);
        rd(12'h16C);
        check("total_vfs", last_rd, 32'h0010_0010);

        // Enable 4 VFs with memory space enable set.
        wr(12'h170, 4'b0011, 32'h4);
        wr(12'h168, 4'b1111, 32'h9);
        busy_cnt = 0; i = 0;
        while (!vf_active && i < 1200) begin
            idle(1);
            if (vf_busy) busy_cnt++;
            i++;
        end
        check("enable_busy_cycles", busy_cnt, ENABLE_WAIT);
        check("on_state", {vf_active, vf_mse, num_vfs_active}, {1'b1, 1'b1, 16'd4});

        wr(12'h170, 4'b0011, 32'h8);
        rd(12'h170);
        check("numvfs_locked", last_rd, 32'h4);

        wr(12'h168, 4'b0001, 32'h8);
        busy_cnt = 0; pulses = 0; i = 0;
        idle(1);
        while (vf_busy && i < 300) begin
            busy_cnt++;
            if (vf_reset) pulses++;
            idle(1);
            i++;
        end
        check("disable_busy_cycles", busy_cnt, DISABLE_WAIT);
        check("disable_pulses", pulses, 1);
        check("nva_cleared", num_vfs_active, 16'd0);

        // Abort halfway through enabling.
        wr(12'h168, 4'b0001, 32'h9);
        saw_active = 0;
        repeat (500) begin idle(1); saw_active |= vf_active; end
        wr(12'h168, 4'b0001, 32'h8);
        i = 0;
        while (vf_busy && i < 300) begin idle(1); saw_active |= vf_active; i++; end
        check("abort_no_active", saw_active, 1'b0);
        check("abort_done", vf_busy, 1'b0);

        wr(12'h170, 4'b0011, 32'h0);
        wr(12'h170, 4'b0011, 32'd17);
        rd(12'h170);
        check("numvfs_over_total", last_rd, 32'h0);
        wr(12'h168, 4'b0010, 32'hFFFF_FFFF);
        rd(12'h168);
        check("ctrl_be1_only", last_rd, 32'h8);
        rd(12'h200);
        check("out_of_window", {last_hit, last_rd}, 33'h0);

        // Same-cycle read and write: read returns old value.
        cycle(1, 1, 12'h170, 4'b0011, 32'h3);
        check("rd_before_wr", last_rd, 32'h0);

        // Reset in the middle of DISABLING.
        wr(12'h170, 4'b0011, 32'h2);
        wr(12'h168, 4'b0001, 32'h1);
        wait_active("reach_on", 1100);
        wr(12'h168, 4'b0001, 32'h0);
        idle(10);
        check("in_disabling", vf_busy, 1'b1);
        #2;
        rst_n = 0;
        #1;
        check("async_reset_outs", {rd_data, rd_valid, rd_hit, vf_active, vf_busy, vf_reset,
                                   vf_mse, num_vfs_active}, 0);
        model_reset();
        pulses = 0;
        repeat (4) begin @(posedge clk); #1; if (vf_reset) pulses++; end
        @(negedge clk);
        rst_n = 1;
        repeat (20) begin idle(1); if (vf_reset) pulses++; end
        check("no_pulse_after_reset", pulses, 0);

        // Random traffic around the window.
        for (int k = 0; k < 4000; k++) begin
            r = ($urandom_range(0, 3) == 0);
            w = ($urandom_range(0, 4) == 0);
            a = 12'h150 + 12'(4 * $urandom_range(0, 19)) + 12'($urandom_range(0, 3));
            d = $urandom;
            if (win_off(a) == 16) d = 32'($urandom_range(0, 20)) | (d & 32'hFFFF_0000);
            if (win_off(a) == 8 && $urandom_range(0, 9) != 0) w = 0;
            cycle(r, w, a, 4'($urandom_range(0, 15)), d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sriov_ext_cap_regs.md
Name: sriov_ext_cap_regs

Overview:
- Parametrised SR-IOV Extended Capability register block: header, Capabilities, Control/Status, InitialVFs/TotalVFs, NumVFs, First VF Offset/VF Stride and VF Device ID dwords.
- Placed at a configurable offset in the PF's extended configuration space.
- Adds byte-enabled writes, registered reads and a VF Enable sequencing FSM that gates the VF population seen by the rest of the function.

Parameters:
- CAP_OFFSET, 12'h160, byte address of capability header (dword aligned, >= 12'h100)
- NEXT_PTR, 12'h000, Next Capability Offset field value (000h = last)
- CAP_VER, 4'h1, capability version field
- SRIOV_CAPS, 32'h0, read-only SR-IOV Capabilities dword
- TOTAL_VFS, 16, TotalVFs and InitialVFs value (1..65535)
- FIRST_VF_OFFSET, 16'h0001, First VF Offset field
- VF_STRIDE, 16'h0001, VF Stride field
- VF_DEVICE_ID, 16'h0000, VF Device ID field
- ENABLE_WAIT, 1000, cycles from VF Enable 0->1 to VFs active (>=1)
- DISABLE_WAIT, 100, cycles of VF teardown after VF Enable 1->0 (>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- addr  in  12  config byte address; addr[1:0] ignored
- wr_en  in  1  write strobe, one cycle per write
- wr_be  in  4  write byte enables
- wr_data  in  32  write data
- rd_en  in  1  read strobe
- rd_data  out  32  read data, registered
- rd_valid  out  1  read data valid, one cycle
- rd_hit  out  1  qualifies rd_valid: address fell inside capability window
- is_last_cap  out  1  1 when NEXT_PTR == 000h (constant)
- vf_active  out  1  VFs enabled and accessible
- vf_busy  out  1  enable/disable sequence in progress
- vf_reset  out  1  one-cycle pulse: reset all VFs
- num_vfs_active  out  16  NumVFs latched at enable
- vf_mse  out  1  VF Memory Space Enable, control bit 3

Behaviour:
- Window: CAP_OFFSET .. CAP_OFFSET+1Ch. Offsets in dwords relative to CAP_OFFSET.
  - 00h: {NEXT_PTR, CAP_VER, 16'h0010}
  - 04h: SRIOV_CAPS
  - 08h: {Status 16'h0, Control}
  - 0Ch: {TotalVFs, InitialVFs}, both TOTAL_VFS
  - 10h: {16'h0, NumVFs}
  - 14h: {VF_STRIDE, FIRST_VF_OFFSET}
  - 18h: {VF_DEVICE_ID, 16'h0}
  - 1Ch: 0
- Control: bit0 VF Enable RW; bit3 VF MSE RW; bit4 ARI Capable Hierarchy RW; all other bits RO 0.
- Writes take effect at the clk edge where wr_en=1; only enabled bytes change. Writes to RO fields and out-of-window addresses are ignored.
- NumVFs and ARI are writable only while VF Enable=0 and FSM is OFF; otherwise the write to those fields is dropped (other bytes still apply). A NumVFs write with value > TOTAL_VFS is dropped whole.
- Read: rd_en at cycle N -> rd_valid=1 at N+1. rd_data shows the value before any same-cycle write. rd_hit=1 if in window, else rd_data=0, rd_hit=0. Reads have no side effects.
- FSM states and transitions:
  - OFF: VF Enable=1 and NumVFs!=0 -> ENABLING. Load counter ENABLE_WAIT-1; latch num_vfs_active=NumVFs.
  - ENABLING: counter decrements each cycle; at 0 -> ON. VF Enable=0 -> DISABLING.
  - ON: VF Enable=0 -> DISABLING.
  - DISABLING: vf_reset=1 on entry cycle only. Counter loads DISABLE_WAIT-1; at 0 -> OFF and num_vfs_active=0. VF Enable writes during DISABLING update the bit but do not abort.
  - On reaching OFF, if VF Enable=1 and NumVFs!=0, go to ENABLING next cycle.
- VF Enable=1 with NumVFs=0: bit reads 1, FSM stays OFF.
- vf_active=1 only in ON; vf_busy=1 in ENABLING or DISABLING. vf_mse = Control bit3 AND vf_active.
- Reset (any time, mid-sequence included): Control=0, NumVFs=0, FSM OFF, counters 0. rd_data=0, rd_valid=0, rd_hit=0, vf_active=0, vf_busy=0, vf_reset=0, num_vfs_active=0, vf_mse=0. No vf_reset pulse generated by reset.

Test Plan:
- Reset, read 160h -> rd_data=0001_0010, rd_valid/rd_hit one cycle later; read 16Ch -> 0010_0010 (TOTAL_VFS=16).
- Write NumVFs=4, write Control=0000_0009 -> vf_busy for 1000 cycles, then vf_active=1, num_vfs_active=4, vf_mse=1.
- While ON write NumVFs=8 -> read back 4. Clear VF Enable -> vf_reset pulse 1 cycle, vf_busy 100 cycles, then num_vfs_active=0.
- Clear VF Enable at cycle 500 of ENABLING -> DISABLING immediately, vf_active never asserts.
- Write NumVFs=17 -> dropped (reads 0). Write wr_be=4'b0010 to control -> bits[15:8] only, VF Enable unchanged. Read 200h -> rd_hit=0, rd_data=0.
- Assert rst_n=0 mid-DISABLING -> all outputs 0 asynchronously, no further vf_reset pulse.
